// File: rtl/cpu_bus_pkg.sv
// rtl/cpu_bus_pkg.sv - shared types and helpers for the 68k bus sequencer
package cpu_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_ACK,
    ST_DONE,
    ST_ERR
  } bus_state_t;

  typedef enum logic {
    TGT_BRAM,
    TGT_SDRAM
  } bus_tgt_t;

  typedef enum logic {
    REQ_CPU,
    REQ_HOST
  } bus_req_t;

  // SDRAM stores the two 16-bit halves in the opposite order to the CPU
  function automatic logic [31:0] half_swap32(input logic [31:0] d);
    return {d[15:0], d[31:16]};
  endfunction

endpackage

// File: rtl/cpu_bus_watchdog.sv
// rtl/cpu_bus_watchdog.sv - clear/enable acknowledge watchdog with terminal-count flag
module cpu_bus_watchdog #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic CLK_114,
  input  logic RESET_N,
  input  logic clr,
  input  logic en,
  output logic tc
);

  // tc fires one count early so the counter reads TIMEOUT_CYC-1 when the FSM sits in ERR
  localparam logic [15:0] TC_COUNT = 16'(TIMEOUT_CYC - 2);

  logic [15:0] count;

  always_ff @(posedge CLK_114 or negedge RESET_N) begin
    if (!RESET_N) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 16'd1;
    end
  end

  assign tc = en && (count == TC_COUNT);

endmodule

// File: rtl/cpu_bus_sequencer.sv
// rtl/cpu_bus_sequencer.sv - 68k bus cycle sequencer: arbitration, BRAM/SDRAM decode, strobes, DTACK/BERR
// Host port and round-robin arbitration are built only when CPU_BUS_HOST_EN is defined.
module cpu_bus_sequencer
  import cpu_bus_pkg::*;
#(
  parameter int BRAM_TOP_BIT = 19,
  parameter int TIMEOUT_CYC  = 255
) (
  input  logic        CLK_114,
  input  logic        RESET_N,
  input  logic        cpu_as_n,
  input  logic [31:0] cpu_addr,
  input  logic        cpu_rw_n,
  input  logic [3:0]  cpu_be,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_dtack_n,
  output logic        cpu_berr_n,
  input  logic        host_req,
  input  logic [31:0] host_addr,
  input  logic        host_we,
  input  logic [3:0]  host_be,
  input  logic [31:0] host_wdata,
  output logic        host_ack,
  output logic        host_err,
  output logic [31:0] host_rdata,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  output logic        bram_en_n,
  output logic        bram_rw_n,
  output logic        sdram_en_n,
  output logic        sdram_rw_n,
  input  logic        bram_dtack,
  input  logic        sdram_dtack,
  input  logic [31:0] bram_rdata,
  input  logic [31:0] sdram_rdata
);

  bus_state_t  state, state_nxt;
  bus_req_t    lat_req, win_req;
  bus_tgt_t    lat_tgt, win_tgt;
  logic        lat_we, err_q, wd_tc;
  logic        host_go, cpu_abort, sel_dtack, capture, grant;
  logic [31:0] win_addr, win_wdata, rd_word;
  logic [3:0]  win_be;
  logic        win_we;

`ifdef CPU_BUS_HOST_EN
  bus_req_t last_grant;

  // Mask the request while our own ack/err is visible: the host drops req only after seeing it
  assign host_go = host_req && !host_ack && !host_err && (cpu_as_n || last_grant == REQ_CPU);

  always_ff @(posedge CLK_114 or negedge RESET_N) begin
    if (!RESET_N) begin
      last_grant <= REQ_HOST;
    end else if (grant) begin
      last_grant <= win_req;
    end
  end
`else
  logic unused_host;
  assign unused_host = ^{host_req, host_addr, host_we, host_be, host_wdata};
  assign host_go     = 1'b0;
`endif

  assign win_req   = host_go ? REQ_HOST : REQ_CPU;
  assign win_addr  = host_go ? host_addr : cpu_addr;
  assign win_we    = host_go ? host_we : !cpu_rw_n;
  assign win_be    = host_go ? host_be : cpu_be;
  assign win_wdata = host_go ? host_wdata : cpu_wdata;
  assign win_tgt   = (win_addr[31:BRAM_TOP_BIT] == '0) ? TGT_BRAM : TGT_SDRAM;

  assign cpu_abort = (lat_req == REQ_CPU) && cpu_as_n;
  assign sel_dtack = (lat_tgt == TGT_SDRAM) ? sdram_dtack : bram_dtack;
  assign rd_word   = (lat_tgt == TGT_SDRAM) ? half_swap32(sdram_rdata) : bram_rdata;
  assign grant     = (state == ST_IDLE) && (state_nxt == ST_ISSUE);
  assign capture   = (state == ST_WAIT_ACK) && (state_nxt == ST_DONE) && !lat_we;

  cpu_bus_watchdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_watchdog (
    .CLK_114 (CLK_114),
    .RESET_N (RESET_N),
    .clr     (state == ST_ISSUE),
    .en      (state == ST_WAIT_ACK),
    .tc      (wd_tc)
  );

  always_ff @(posedge CLK_114 or negedge RESET_N) begin
    if (!RESET_N) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:     if (!cpu_as_n || host_go) state_nxt = ST_ISSUE;
      ST_ISSUE:    state_nxt = cpu_abort ? ST_IDLE : ST_WAIT_ACK;
      ST_WAIT_ACK: begin
        if (cpu_abort)      state_nxt = ST_IDLE;
        else if (sel_dtack) state_nxt = ST_DONE;
        else if (wd_tc)     state_nxt = ST_ERR;
      end
      ST_ERR:      state_nxt = ST_DONE;
      ST_DONE:     if (lat_req == REQ_HOST || cpu_as_n) state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK_114 or negedge RESET_N) begin
    if (!RESET_N) begin
      lat_req     <= REQ_CPU;
      lat_tgt     <= TGT_BRAM;
      lat_we      <= 1'b0;
      err_q       <= 1'b0;
      mem_addr    <= '0;
      mem_be      <= '0;
      mem_wdata   <= '0;
      cpu_rdata   <= '0;
      cpu_dtack_n <= 1'b1;
      cpu_berr_n  <= 1'b1;
      bram_en_n   <= 1'b1;
      bram_rw_n   <= 1'b1;
      sdram_en_n  <= 1'b1;
      sdram_rw_n  <= 1'b1;
    end else begin
      if (grant) begin
        lat_req   <= win_req;
        lat_tgt   <= win_tgt;
        lat_we    <= win_we;
        mem_addr  <= win_addr;
        mem_be    <= (win_tgt == TGT_SDRAM) ? {win_be[1:0], win_be[3:2]} : win_be;
        mem_wdata <= (win_tgt == TGT_SDRAM) ? half_swap32(win_wdata) : win_wdata;
      end
      if (state == ST_ISSUE) begin
        err_q <= 1'b0;
      end else if (state_nxt == ST_ERR) begin
        err_q <= 1'b1;
      end
      // Strobes follow the next state so they drop the same edge the cycle ends or aborts
      bram_en_n  <= !(state_nxt == ST_WAIT_ACK && lat_tgt == TGT_BRAM);
      bram_rw_n  <= !(state_nxt == ST_WAIT_ACK && lat_tgt == TGT_BRAM && lat_we);
      sdram_en_n <= !(state_nxt == ST_WAIT_ACK && lat_tgt == TGT_SDRAM);
      sdram_rw_n <= !(state_nxt == ST_WAIT_ACK && lat_tgt == TGT_SDRAM && lat_we);
      if (capture && lat_req == REQ_CPU) begin
        cpu_rdata <= rd_word;
      end
      cpu_dtack_n <= !(lat_req == REQ_CPU && !cpu_as_n && state == ST_DONE && !err_q);
      cpu_berr_n  <= !(lat_req == REQ_CPU && !cpu_as_n &&
                       (state == ST_ERR || (state == ST_DONE && err_q)));
    end
  end

`ifdef CPU_BUS_HOST_EN
  always_ff @(posedge CLK_114 or negedge RESET_N) begin
    if (!RESET_N) begin
      host_ack   <= 1'b0;
      host_err   <= 1'b0;
      host_rdata <= '0;
    end else begin
      host_ack <= (state == ST_DONE) && (lat_req == REQ_HOST) && !err_q;
      host_err <= (state == ST_DONE) && (lat_req == REQ_HOST) && err_q;
      if (capture && lat_req == REQ_HOST) begin
        host_rdata <= rd_word;
      end
    end
  end
`else
  assign host_ack   = 1'b0;
  assign host_err   = 1'b0;
  assign host_rdata = '0;
`endif

endmodule

// File: tb/tb_cpu_bus_sequencer.sv
// tb/tb_cpu_bus_sequencer.sv - scoreboard bench for cpu_bus_sequencer (host tests need CPU_BUS_HOST_EN)
module tb_cpu_bus_sequencer;

  logic        CLK_114, RESET_N;
  logic        cpu_as_n, cpu_rw_n;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic [3:0]  cpu_be;
  logic        cpu_dtack_n, cpu_berr_n;
  logic        host_req, host_we, host_ack, host_err;
  logic [31:0] host_addr, host_wdata, host_rdata;
  logic [3:0]  host_be;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        bram_en_n, bram_rw_n, sdram_en_n, sdram_rw_n;
  logic        bram_dtack, sdram_dtack;
  logic [31:0] bram_rdata, sdram_rdata;

  cpu_bus_sequencer #(.BRAM_TOP_BIT(19), .TIMEOUT_CYC(8)) dut (
    .CLK_114(CLK_114), .RESET_N(RESET_N),
    .cpu_as_n(cpu_as_n), .cpu_addr(cpu_addr), .cpu_rw_n(cpu_rw_n), .cpu_be(cpu_be),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_dtack_n(cpu_dtack_n),
    .cpu_berr_n(cpu_berr_n), .host_req(host_req), .host_addr(host_addr),
    .host_we(host_we), .host_be(host_be), .host_wdata(host_wdata),
    .host_ack(host_ack), .host_err(host_err), .host_rdata(host_rdata),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .bram_en_n(bram_en_n), .bram_rw_n(bram_rw_n), .sdram_en_n(sdram_en_n),
    .sdram_rw_n(sdram_rw_n), .bram_dtack(bram_dtack), .sdram_dtack(sdram_dtack),
    .bram_rdata(bram_rdata), .sdram_rdata(sdram_rdata)
  );

  typedef struct {
    int          kind;   // 0 dtack, 1 berr, 2 host_ack, 3 host_err
    logic [31:0] data;
    bit          chk;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          ack_cnt = 0;
  int          bram_delay = 1, sdram_delay = 1, bcnt = 0, scnt = 0;
  logic        late_ack = 1'b0;
  logic [31:0] bram_data_v = '0, sdram_data_v = '0;
  logic        p_dtack = 1'b1, p_berr = 1'b1;
  int          lat;
  logic [3:0]  seen;

  initial CLK_114 = 1'b0;
  always #5 CLK_114 = ~CLK_114;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic push(input int kind, input logic [31:0] data, input bit c);
    exp_t e;
    e.kind = kind; e.data = data; e.chk = c;
    exp_q.push_back(e);
  endtask

  task automatic check_evt(input int kind, input logic [31:0] data);
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event kind=%0d data=%h required=none", kind, data);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || (e.chk && data !== e.data)) begin
        errors++;
        $display("FAIL event kind=%0d data=%h required kind=%0d data=%h", kind, data, e.kind, e.data);
      end
    end
  endtask

  // Target model: ack after N enabled cycles (0 = never), plus a forced late ack
  always @(negedge CLK_114) begin
    if (!bram_en_n) bcnt++; else bcnt = 0;
    if (!sdram_en_n) scnt++; else scnt = 0;
    bram_dtack  = (bram_delay != 0 && bcnt == bram_delay) || late_ack;
    sdram_dtack = (sdram_delay != 0 && scnt == sdram_delay);
    bram_rdata  = bram_data_v;
    sdram_rdata = sdram_data_v;
  end

  // Monitor: each DTACK/BERR assertion or host pulse is matched against the scoreboard
  always @(negedge CLK_114) begin
    if (RESET_N) begin
      if (!cpu_dtack_n && p_dtack) check_evt(0, cpu_rdata);
      if (!cpu_berr_n && p_berr)   check_evt(1, cpu_rdata);
      if (host_ack) begin ack_cnt++; check_evt(2, host_rdata); end
      if (host_err) check_evt(3, host_rdata);
    end
    p_dtack = cpu_dtack_n;
    p_berr  = cpu_berr_n;
  end

  task automatic cpu_cycle(input logic [31:0] a, input logic rd, input logic [3:0] be,
                           input logic [31:0] wd, input logic exp_berr,
                           output int l, output logic [3:0] s);
    @(negedge CLK_114);
    cpu_addr = a; cpu_rw_n = rd; cpu_be = be; cpu_wdata = wd; cpu_as_n = 1'b0;
    l = -1; s = '0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge CLK_114);
      s = s | {~bram_en_n, ~sdram_en_n, ~bram_rw_n, ~sdram_rw_n};
      if (!cpu_dtack_n || !cpu_berr_n) begin
        l = i - 1;
        break;
      end
    end
    chk("cycle_en_off", {30'd0, bram_en_n, sdram_en_n}, 32'd3);
    repeat (2) @(negedge CLK_114);
    chk("cycle_held", {30'd0, cpu_dtack_n, cpu_berr_n}, exp_berr ? 32'd2 : 32'd1);
    cpu_as_n = 1'b1;
    @(negedge CLK_114);
    chk("cycle_release", {30'd0, cpu_dtack_n, cpu_berr_n}, 32'd3);
  endtask

  task automatic host_cycle(input logic [31:0] a, input logic we, input logic [3:0] be,
                            input logic [31:0] wd);
    logic ok;
    ok = 1'b0;
    @(negedge CLK_114);
    host_addr = a; host_we = we; host_be = be; host_wdata = wd; host_req = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge CLK_114);
      if (host_ack || host_err) begin
        ok = 1'b1;
        break;
      end
    end
    host_req = 1'b0;
    chk("host_done", {31'd0, ok}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    RESET_N = 1'b0;
    cpu_as_n = 1'b1; cpu_addr = '0; cpu_rw_n = 1'b1; cpu_be = '0; cpu_wdata = '0;
    host_req = 1'b0; host_addr = '0; host_we = 1'b0; host_be = '0; host_wdata = '0;
    repeat (3) @(negedge CLK_114);
    chk("reset_ctrl", {24'd0, cpu_dtack_n, cpu_berr_n, bram_en_n, sdram_en_n,
                       bram_rw_n, sdram_rw_n, host_ack, host_err}, 32'h0000_00FC);
    chk("reset_bus", cpu_rdata | mem_addr | mem_wdata | host_rdata | {28'd0, mem_be}, 32'd0);
    RESET_N = 1'b1;

`ifdef CPU_BUS_HOST_EN
    // Simultaneous CPU/host requests twice: CPU wins each tie, so its latency stays minimal
    bram_data_v = 32'hCAFE_F00D; sdram_data_v = 32'h0102_0304;
    bram_delay = 1; sdram_delay = 1;
    for (int r = 0; r < 2; r++) begin
      push(0, 32'hCAFE_F00D, 1'b1);
      push(2, 32'h0304_0102, 1'b1);
      fork
        cpu_cycle(32'h0000_0040, 1'b1, 4'hF, 32'd0, 1'b0, lat, seen);
        host_cycle(32'h0100_0000, 1'b0, 4'hF, 32'd0);
      join
      chk("tie_cpu_first_lat", lat, 32'd3);
    end
`else
    @(negedge CLK_114);
    host_req = 1'b1; host_addr = 32'h0000_0100; seen = '0;
    repeat (10) begin
      @(negedge CLK_114);
      seen = seen | {1'b0, ~bram_en_n, ~sdram_en_n, host_ack};
    end
    host_req = 1'b0;
    chk("host_ignored", {28'd0, seen}, 32'd0);
`endif

    // BRAM read, ack after 2 enabled cycles
    bram_delay = 2; bram_data_v = 32'h1122_3344;
    push(0, 32'h1122_3344, 1'b1);
    cpu_cycle(32'h0000_1000, 1'b1, 4'hF, 32'd0, 1'b0, lat, seen);
    chk("bram_rd_lat", lat, 32'd4);
    chk("bram_rd_strobes", {28'd0, seen}, 32'h8);

    // Highest BRAM word, ack in first WAIT_ACK cycle: minimum latency
    bram_delay = 1; bram_data_v = 32'h0BAD_BEEF;
    push(0, 32'h0BAD_BEEF, 1'b1);
    cpu_cycle(32'h0007_FFFC, 1'b1, 4'hF, 32'd0, 1'b0, lat, seen);
    chk("min_lat", lat, 32'd3);
    chk("bram_top_strobes", {28'd0, seen}, 32'h8);

    // SDRAM write: halves and byte strobes swapped
    sdram_delay = 1;
    push(0, 32'd0, 1'b0);
    cpu_cycle(32'h0010_0000, 1'b0, 4'b1100, 32'hAABB_CCDD, 1'b0, lat, seen);
    chk("sdram_wr_strobes", {28'd0, seen}, 32'h5);
    chk("sdram_wr_data", mem_wdata, 32'hCCDD_AABB);
    chk("sdram_wr_be", {28'd0, mem_be}, 32'h3);
    chk("sdram_wr_addr", mem_addr, 32'h0010_0000);

    // First SDRAM address, read swapped back
    sdram_delay = 3; sdram_data_v = 32'h5566_7788;
    push(0, 32'h7788_5566, 1'b1);
    cpu_cycle(32'h0008_0000, 1'b1, 4'b0001, 32'd0, 1'b0, lat, seen);
    chk("sdram_rd_lat", lat, 32'd5);
    chk("sdram_rd_strobes", {28'd0, seen}, 32'h4);
    chk("sdram_rd_be", {28'd0, mem_be}, 32'h4);

    // BRAM write passes through unswapped
    bram_delay = 1;
    push(0, 32'd0, 1'b0);
    cpu_cycle(32'h0000_0010, 1'b0, 4'b0110, 32'h1234_5678, 1'b0, lat, seen);
    chk("bram_wr_strobes", {28'd0, seen}, 32'hA);
    chk("bram_wr_data", mem_wdata, 32'h1234_5678);
    chk("bram_wr_be", {28'd0, mem_be}, 32'h6);

    // No SDRAM ack: one ISSUE cycle plus 8 watchdog cycles to BERR
    sdram_delay = 0;
    push(1, 32'd0, 1'b0);
    cpu_cycle(32'h2000_0000, 1'b1, 4'hF, 32'd0, 1'b1, lat, seen);
    chk("timeout_lat", lat, 32'd9);
    chk("timeout_strobes", {28'd0, seen}, 32'h4);

    // Abort in WAIT_ACK, then a late ack that must be ignored
    bram_delay = 0;
    @(negedge CLK_114);
    cpu_addr = 32'h0000_0100; cpu_rw_n = 1'b1; cpu_be = 4'hF; cpu_as_n = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK_114);
      if (!bram_en_n) break;
    end
    chk("abort_en_on", {31'd0, bram_en_n}, 32'd0);
    @(negedge CLK_114);
    cpu_as_n = 1'b1;
    @(negedge CLK_114);
    chk("abort_en_off", {30'd0, bram_en_n, sdram_en_n}, 32'd3);
    late_ack = 1'b1;
    repeat (2) @(negedge CLK_114);
    late_ack = 1'b0;
    repeat (4) @(negedge CLK_114);
    chk("abort_no_ack", {30'd0, cpu_dtack_n, cpu_berr_n}, 32'd3);
    bram_delay = 1; bram_data_v = 32'h9988_7766;
    push(0, 32'h9988_7766, 1'b1);
    cpu_cycle(32'h0000_0104, 1'b1, 4'hF, 32'd0, 1'b0, lat, seen);
    chk("after_abort_lat", lat, 32'd3);

    // Asynchronous reset during WAIT_ACK, then a normal read
    bram_delay = 0;
    @(negedge CLK_114);
    cpu_addr = 32'h0000_0300; cpu_rw_n = 1'b1; cpu_as_n = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK_114);
      if (!bram_en_n) break;
    end
    @(negedge CLK_114);
    #2 RESET_N = 1'b0;
    #1;
    chk("async_reset_ctrl", {24'd0, cpu_dtack_n, cpu_berr_n, bram_en_n, sdram_en_n,
                             bram_rw_n, sdram_rw_n, host_ack, host_err}, 32'h0000_00FC);
    chk("async_reset_bus", cpu_rdata | mem_addr | mem_wdata | {28'd0, mem_be}, 32'd0);
    cpu_as_n = 1'b1;
    @(negedge CLK_114);
    RESET_N = 1'b1;
    bram_delay = 1; bram_data_v = 32'h4455_6677;
    push(0, 32'h4455_6677, 1'b1);
    cpu_cycle(32'h0000_0304, 1'b1, 4'hF, 32'd0, 1'b0, lat, seen);
    chk("after_reset_lat", lat, 32'd3);

    repeat (5) @(negedge CLK_114);
    chk("scoreboard_empty", exp_q.size(), 32'd0);
`ifdef CPU_BUS_HOST_EN
    chk("host_ack_pulses", ack_cnt, 32'd2);
`else
    chk("host_ack_pulses", ack_cnt, 32'd0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
